// File: rtl/gba_cart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gba_cart_pkg
// Description : Shared types and constants for the game-pak bus sequencer.
//               Holds the FSM state and region enums, the region base bytes,
//               the WAITCNT field positions and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package gba_cart_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC_LO = 2'd1,
      ACC_HI = 2'd2,
      DONE   = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      WS0  = 3'd0,
      WS1  = 3'd1,
      WS2  = 3'd2,
      SRAM = 3'd3,
      NONE = 3'd4
   } region_e;

   // Each region spans two 16 MiB pages starting at these address bytes.
   localparam logic [7:0] C_WS0_BASE  = 8'h08;
   localparam logic [7:0] C_WS1_BASE  = 8'h0A;
   localparam logic [7:0] C_WS2_BASE  = 8'h0C;
   localparam logic [7:0] C_SRAM_BASE = 8'h0E;

   // WAITCNT field positions.
   localparam int C_SRAM_LSB = 0;
   localparam int C_WS0N_LSB = 2;
   localparam int C_WS0S_BIT = 4;
   localparam int C_WS1N_LSB = 5;
   localparam int C_WS1S_BIT = 7;
   localparam int C_WS2N_LSB = 8;
   localparam int C_WS2S_BIT = 10;

   // Address size encodings.
   localparam logic [1:0] C_SIZE_BYTE = 2'd0;
   localparam logic [1:0] C_SIZE_HALF = 2'd1;
   localparam logic [1:0] C_SIZE_WORD = 2'd2;

   // Two-bit N-wait field: 0..3 -> 4,3,2,8 cycles.
   function automatic logic [3:0] n_wait(input logic [1:0] field);
      logic [3:0] w;
      case (field)
         2'd0:    w = 4'd4;
         2'd1:    w = 4'd3;
         2'd2:    w = 4'd2;
         default: w = 4'd8;
      endcase
      return w;
   endfunction

   // Region from the top address byte; anything outside 0x08..0x0F is NONE.
   function automatic region_e region_of(input logic [31:0] a);
      region_e r;
      if      (a[31:25] == C_WS0_BASE[7:1])  r = WS0;
      else if (a[31:25] == C_WS1_BASE[7:1])  r = WS1;
      else if (a[31:25] == C_WS2_BASE[7:1])  r = WS2;
      else if (a[31:25] == C_SRAM_BASE[7:1]) r = SRAM;
      else                                   r = NONE;
      return r;
   endfunction

   // Byte lane of a 32-bit word selected by the low address bits.
   function automatic logic [7:0] byte_lane(input logic [31:0] d, input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gba_cart_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : gba_cart_bus_sequencer_if
// Description : CPU/DMA side of the game-pak access: request, address,
//               direction, size, write data, read data and the stall.
// Revision    : 1.0 - initial release
// ============================================================================
interface gba_cart_bus_sequencer_if;
   logic        req;
   logic [31:0] addr;
   logic        write;
   logic [1:0]  size;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        pause;

   modport master (
      output req, addr, write, size, wdata,
      input  rdata, pause
   );

   modport slave (
      input  req, addr, write, size, wdata,
      output rdata, pause
   );
endinterface
`default_nettype wire

// File: rtl/gba_cart_wait_lut.sv
`default_nettype none
// ============================================================================
// Module      : gba_cart_wait_lut
// Description : Combinational wait-state lookup. Returns the number of wait
//               cycles for one halfword/byte in the given region, using the
//               N or S field of WAITCNT. SRAM always uses its single field.
// Revision    : 1.0 - initial release
// ============================================================================
module gba_cart_wait_lut
   import gba_cart_pkg::*;
(
   input  region_e     region_i,
   input  logic        seq_i,
   input  logic [15:0] waitcnt_i,
   output logic [3:0]  wait_o
);

   // Select the region field, S timing only when the access is sequential.
   always_comb begin
      wait_o = 4'd8;
      case (region_i)
         WS0:  wait_o = seq_i ? (waitcnt_i[C_WS0S_BIT] ? 4'd1 : 4'd2)
                              : n_wait(waitcnt_i[C_WS0N_LSB +: 2]);
         WS1:  wait_o = seq_i ? (waitcnt_i[C_WS1S_BIT] ? 4'd1 : 4'd4)
                              : n_wait(waitcnt_i[C_WS1N_LSB +: 2]);
         WS2:  wait_o = seq_i ? (waitcnt_i[C_WS2S_BIT] ? 4'd1 : 4'd8)
                              : n_wait(waitcnt_i[C_WS2N_LSB +: 2]);
         SRAM: wait_o = n_wait(waitcnt_i[C_SRAM_LSB +: 2]);
         default: wait_o = 4'd8;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/gba_cart_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gba_cart_bus_sequencer
// Description : Sequences game-pak accesses on the 16-bit cartridge bus.
//               Applies WAITCNT N/S timing per region, splits 32-bit ROM
//               accesses into low/high halfwords, runs SRAM as 8-bit and
//               stalls the CPU/DMA until the data is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module gba_cart_bus_sequencer
   import gba_cart_pkg::*;
#(
   parameter int ROM_BOUNDARY_BITS = 17,
   parameter bit SRAM_BYTE_ONLY    = 1'b1
)(
   input  logic                      clk_i,
   input  logic                      rst_b_i,
   gba_cart_bus_sequencer_if.slave   bus,
   input  logic [15:0]               waitcnt_i,
   output logic [31:0]               cart_addr_o,
   output logic                      cart_rd_o,
   output logic                      cart_wr_o,
   output logic [15:0]               cart_wdata_o,
   input  logic [15:0]               cart_rdata_i
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   // Attributes of the access in flight, captured at its first edge.
   logic [31:0] acc_addr_q, acc_addr_d;
   logic [1:0]  acc_size_q, acc_size_d;
   logic        acc_write_q, acc_write_d;
   logic        acc_byte_q, acc_byte_d;
   region_e     acc_region_q, acc_region_d;
   logic [15:0] acc_wdata_hi_q, acc_wdata_hi_d;

   // Last completed access, for sequential eligibility.
   logic [31:0] last_addr_q, last_addr_d;
   logic        last_word_q, last_word_d;
   logic        last_write_q, last_write_d;
   region_e     last_region_q, last_region_d;
   logic        seq_valid_q, seq_valid_d;

   logic [31:0] rdata_q, rdata_d;
   logic [31:0] cart_addr_q, cart_addr_d;
   logic        cart_rd_q, cart_rd_d;
   logic        cart_wr_q, cart_wr_d;
   logic [15:0] cart_wdata_q, cart_wdata_d;

   region_e     w_region;
   logic        w_byte;
   logic        w_seq;
   logic [31:0] w_step;
   logic [3:0]  w_wait_first;
   logic [3:0]  w_wait_s;
   logic        w_split;
   logic [15:0] w_wdata_first;

   assign w_region = region_of(bus.addr);
   assign w_byte   = SRAM_BYTE_ONLY && (w_region == SRAM);
   assign w_step   = last_word_q ? 32'd4 : 32'd2;
   assign w_split  = (acc_size_q == C_SIZE_WORD) && !acc_byte_q;

   // Sequential only if nothing about the stream broke since the last access.
   assign w_seq = seq_valid_q
                  && (w_region != NONE)
                  && (w_region == last_region_q)
                  && (bus.write == last_write_q)
                  && (bus.addr == last_addr_q + w_step)
                  && (bus.addr[31:ROM_BOUNDARY_BITS] == last_addr_q[31:ROM_BOUNDARY_BITS]);

   // First halfword of the incoming request (N or S) and the second half (always S).
   gba_cart_wait_lut u_lut_first (
      .region_i  (w_region),
      .seq_i     (w_seq),
      .waitcnt_i (waitcnt_i),
      .wait_o    (w_wait_first)
   );

   gba_cart_wait_lut u_lut_s (
      .region_i  (acc_region_q),
      .seq_i     (1'b1),
      .waitcnt_i (waitcnt_i),
      .wait_o    (w_wait_s)
   );

   // Data driven on the pins for the first strobe of a write.
   always_comb begin
      if (w_byte)
         w_wdata_first = {8'h00, byte_lane(bus.wdata, bus.addr[1:0])};
      else if (bus.size == C_SIZE_WORD || !bus.addr[1])
         w_wdata_first = bus.wdata[15:0];
      else
         w_wdata_first = bus.wdata[31:16];
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state: a dropped request aborts any access phase immediately.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (bus.req) state_d = ACC_LO;
         ACC_LO: if (!bus.req)         state_d = IDLE;
                 else if (cnt_q == 4'd0) state_d = w_split ? ACC_HI : DONE;
         ACC_HI: if (!bus.req)         state_d = IDLE;
                 else if (cnt_q == 4'd0) state_d = DONE;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stall the requester until the single DONE cycle.
   always_comb begin
      bus.pause = bus.req && (state_q != DONE);
   end

   assign bus.rdata    = rdata_q;
   assign cart_addr_o  = cart_addr_q;
   assign cart_rd_o    = cart_rd_q;
   assign cart_wr_o    = cart_wr_q;
   assign cart_wdata_o = cart_wdata_q;

   // Datapath: wait counter, strobes, pin address, data assembly, last-access tracker.
   always_comb begin
      cnt_d          = cnt_q;
      acc_addr_d     = acc_addr_q;
      acc_size_d     = acc_size_q;
      acc_write_d    = acc_write_q;
      acc_byte_d     = acc_byte_q;
      acc_region_d   = acc_region_q;
      acc_wdata_hi_d = acc_wdata_hi_q;
      last_addr_d    = last_addr_q;
      last_word_d    = last_word_q;
      last_write_d   = last_write_q;
      last_region_d  = last_region_q;
      seq_valid_d    = seq_valid_q;
      rdata_d        = rdata_q;
      cart_addr_d    = cart_addr_q;
      cart_rd_d      = 1'b0;
      cart_wr_d      = 1'b0;
      cart_wdata_d   = cart_wdata_q;

      case (state_q)
         IDLE: begin
            if (bus.req) begin
               // Counter holds remaining waits after this one, so ACC_LO lasts W cycles.
               cnt_d          = w_wait_first - 4'd1;
               acc_addr_d     = bus.addr;
               acc_size_d     = bus.size;
               acc_write_d    = bus.write;
               acc_byte_d     = w_byte;
               acc_region_d   = w_region;
               acc_wdata_hi_d = bus.wdata[31:16];
               cart_addr_d    = w_byte ? bus.addr : {bus.addr[31:1], 1'b0};
               cart_rd_d      = !bus.write;
               cart_wr_d      = bus.write;
               cart_wdata_d   = w_wdata_first;
            end
         end

         ACC_LO: begin
            if (!bus.req) begin
               seq_valid_d = 1'b0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!acc_write_q) begin
                  if (acc_byte_q)   rdata_d = {4{cart_rdata_i[7:0]}};
                  else if (w_split) rdata_d = {rdata_q[31:16], cart_rdata_i};
                  else              rdata_d = {2{cart_rdata_i}};
               end
               if (w_split) begin
                  // High half has its own address cycle, so it costs 1 + S.
                  cnt_d        = w_wait_s;
                  cart_addr_d  = cart_addr_q + 32'd2;
                  cart_rd_d    = !acc_write_q;
                  cart_wr_d    = acc_write_q;
                  cart_wdata_d = acc_wdata_hi_q;
               end else begin
                  last_addr_d   = acc_addr_q;
                  last_word_d   = (acc_size_q == C_SIZE_WORD);
                  last_write_d  = acc_write_q;
                  last_region_d = acc_region_q;
                  seq_valid_d   = 1'b1;
               end
            end
         end

         ACC_HI: begin
            if (!bus.req) begin
               seq_valid_d = 1'b0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!acc_write_q) rdata_d = {cart_rdata_i, rdata_q[15:0]};
               last_addr_d   = acc_addr_q;
               last_word_d   = 1'b1;
               last_write_d  = acc_write_q;
               last_region_d = acc_region_q;
               seq_valid_d   = 1'b1;
            end
         end

         default: ;
      endcase
   end

   // Datapath registers; reset kills any strobe in flight.
   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         cnt_q          <= 4'd0;
         acc_addr_q     <= 32'd0;
         acc_size_q     <= 2'd0;
         acc_write_q    <= 1'b0;
         acc_byte_q     <= 1'b0;
         acc_region_q   <= NONE;
         acc_wdata_hi_q <= 16'd0;
         last_addr_q    <= 32'd0;
         last_word_q    <= 1'b0;
         last_write_q   <= 1'b0;
         last_region_q  <= NONE;
         seq_valid_q    <= 1'b0;
         rdata_q        <= 32'd0;
         cart_addr_q    <= 32'd0;
         cart_rd_q      <= 1'b0;
         cart_wr_q      <= 1'b0;
         cart_wdata_q   <= 16'd0;
      end else begin
         cnt_q          <= cnt_d;
         acc_addr_q     <= acc_addr_d;
         acc_size_q     <= acc_size_d;
         acc_write_q    <= acc_write_d;
         acc_byte_q     <= acc_byte_d;
         acc_region_q   <= acc_region_d;
         acc_wdata_hi_q <= acc_wdata_hi_d;
         last_addr_q    <= last_addr_d;
         last_word_q    <= last_word_d;
         last_write_q   <= last_write_d;
         last_region_q  <= last_region_d;
         seq_valid_q    <= seq_valid_d;
         rdata_q        <= rdata_d;
         cart_addr_q    <= cart_addr_d;
         cart_rd_q      <= cart_rd_d;
         cart_wr_q      <= cart_wr_d;
         cart_wdata_q   <= cart_wdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gba_cart_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gba_cart_bus_sequencer
// Description : Directed self-checking bench for the game-pak bus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gba_cart_bus_sequencer;

   logic        clk;
   logic        rst_b;
   logic [15:0] waitcnt;
   logic [31:0] cart_addr;
   logic        cart_rd;
   logic        cart_wr;
   logic [15:0] cart_wdata;
   logic [15:0] cart_rdata;
   bit          beef_mode;

   int tests_run;
   int tests_failed;

   // Strobe log of the most recent access.
   logic [31:0] log_addr [8];
   logic [15:0] log_wd   [8];
   int          n_log;

   gba_cart_bus_sequencer_if bus ();

   gba_cart_bus_sequencer #(
      .ROM_BOUNDARY_BITS (17),
      .SRAM_BYTE_ONLY    (1'b1)
   ) dut (
      .clk_i        (clk),
      .rst_b_i      (rst_b),
      .bus          (bus.slave),
      .waitcnt_i    (waitcnt),
      .cart_addr_o  (cart_addr),
      .cart_rd_o    (cart_rd),
      .cart_wr_o    (cart_wr),
      .cart_wdata_o (cart_wdata),
      .cart_rdata_i (cart_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cartridge model: constant pattern or address-derived data.
   always_comb begin
      cart_rdata = beef_mode ? 16'hBEEF : (cart_addr[15:0] + 16'h1000);
   end

   // Runs one access from a negedge; counts pause cycles and strobes.
   task automatic do_access(input logic [31:0] a, input logic w, input logic [1:0] s,
                            input logic [31:0] wd, input bit keep,
                            output int cyc, output int nrd, output int nwr, output bit tmo);
      bit done;
      bus.addr  = a;
      bus.write = w;
      bus.size  = s;
      bus.wdata = wd;
      bus.req   = 1'b1;
      cyc = 0; nrd = 0; nwr = 0; tmo = 1'b0; n_log = 0; done = 1'b0;
      while (!done) begin
         #1;
         if (bus.pause === 1'b0) begin
            done = 1'b1;
         end else begin
            cyc++;
            if (cart_rd === 1'b1 || cart_wr === 1'b1) begin
               if (n_log < 8) begin
                  log_addr[n_log] = cart_addr;
                  log_wd[n_log]   = cart_wdata;
               end
               n_log++;
            end
            if (cart_rd === 1'b1) nrd++;
            if (cart_wr === 1'b1) nwr++;
            if (cyc > 60) begin
               tmo  = 1'b1;
               done = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
      end
      if (!keep) bus.req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_b   = 1'b0;
      bus.req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if (bus.pause !== 1'b0 || bus.rdata !== 32'd0 || cart_addr !== 32'd0 ||
          cart_rd !== 1'b0 || cart_wr !== 1'b0 || cart_wdata !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: pause=%b rdata=%h addr=%h rd=%b wr=%b wd=%h, want all zero",
                  bus.pause, bus.rdata, cart_addr, cart_rd, cart_wr, cart_wdata);
      end
      bus.req = 1'b1;
      #1;
      tests_run++;
      if (bus.pause !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_pause_eq_req: pause=%b want 1", bus.pause);
      end
      bus.req = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_half_read();
      int cyc, nrd, nwr; bit tmo;
      waitcnt = 16'h0000; beef_mode = 1'b1;
      do_access(32'h0800_0000, 1'b0, 2'd1, 32'd0, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 5 || nrd != 1 || nwr != 0) begin
         tests_failed++;
         $display("FAIL half_read_timing: tmo=%b cycles=%0d rd=%0d wr=%0d, want 0/5/1/0", tmo, cyc, nrd, nwr);
      end
      tests_run++;
      if (bus.rdata !== 32'hBEEF_BEEF || log_addr[0] !== 32'h0800_0000) begin
         tests_failed++;
         $display("FAIL half_read_data: rdata=%h addr=%h, want BEEFBEEF 08000000", bus.rdata, log_addr[0]);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, nrd, nwr; bit tmo;
      waitcnt = 16'h0000; beef_mode = 1'b0;
      do_access(32'h0800_0000, 1'b0, 2'd2, 32'd0, 1'b1, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 8 || nrd != 2 || log_addr[0] !== 32'h0800_0000 || log_addr[1] !== 32'h0800_0002) begin
         tests_failed++;
         $display("FAIL b2b_word0: tmo=%b cycles=%0d rd=%0d a0=%h a1=%h, want 8 2 08000000 08000002",
                  tmo, cyc, nrd, log_addr[0], log_addr[1]);
      end
      tests_run++;
      if (bus.rdata !== 32'h1002_1000) begin
         tests_failed++;
         $display("FAIL b2b_word0_data: rdata=%h want 10021000", bus.rdata);
      end
      do_access(32'h0800_0004, 1'b0, 2'd2, 32'd0, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 6 || nrd != 2 || log_addr[0] !== 32'h0800_0004 || log_addr[1] !== 32'h0800_0006) begin
         tests_failed++;
         $display("FAIL b2b_word1: tmo=%b cycles=%0d rd=%0d a0=%h a1=%h, want 6 2 08000004 08000006",
                  tmo, cyc, nrd, log_addr[0], log_addr[1]);
      end
      tests_run++;
      if (bus.rdata !== 32'h1006_1004) begin
         tests_failed++;
         $display("FAIL b2b_word1_data: rdata=%h want 10061004", bus.rdata);
      end
   endtask

   task automatic test_seq_boundary();
      int cyc, nrd, nwr; bit tmo;
      // WS0 N field = 2 -> 2 waits, S bit = 1 -> 1 wait.
      waitcnt = 16'h0018; beef_mode = 1'b0;
      do_access(32'h0800_0100, 1'b0, 2'd2, 32'd0, 1'b1, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 5) begin
         tests_failed++;
         $display("FAIL seq_first_N: tmo=%b cycles=%0d want 5", tmo, cyc);
      end
      do_access(32'h0800_0104, 1'b0, 2'd2, 32'd0, 1'b1, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 4) begin
         tests_failed++;
         $display("FAIL seq_next_S: tmo=%b cycles=%0d want 4", tmo, cyc);
      end
      do_access(32'h0801_FFFC, 1'b0, 2'd2, 32'd0, 1'b1, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 5 || log_addr[1] !== 32'h0801_FFFE) begin
         tests_failed++;
         $display("FAIL seq_jump_N: tmo=%b cycles=%0d a1=%h want 5 0801FFFE", tmo, cyc, log_addr[1]);
      end
      do_access(32'h0802_0000, 1'b0, 2'd2, 32'd0, 1'b1, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 5) begin
         tests_failed++;
         $display("FAIL seq_boundary_N: tmo=%b cycles=%0d want 5", tmo, cyc);
      end
      // Sequential address but direction flips: N timing, ROM write strobes cart_wr.
      do_access(32'h0802_0004, 1'b1, 2'd1, 32'h1234_5678, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 3 || nrd != 0 || nwr != 1 || log_wd[0] !== 16'h5678) begin
         tests_failed++;
         $display("FAIL rom_write_after_read: tmo=%b cycles=%0d rd=%0d wr=%0d wd=%h want 3 0 1 5678",
                  tmo, cyc, nrd, nwr, log_wd[0]);
      end
   endtask

   task automatic test_sram();
      int cyc, nrd, nwr; bit tmo;
      waitcnt = 16'h0003; beef_mode = 1'b0;
      do_access(32'h0E00_0003, 1'b1, 2'd2, 32'hAABB_CCDD, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 9 || nwr != 1 || nrd != 0) begin
         tests_failed++;
         $display("FAIL sram_write_timing: tmo=%b cycles=%0d wr=%0d rd=%0d want 9 1 0", tmo, cyc, nwr, nrd);
      end
      tests_run++;
      if (log_wd[0][7:0] !== 8'hAA || log_addr[0] !== 32'h0E00_0003) begin
         tests_failed++;
         $display("FAIL sram_write_data: wd=%h addr=%h want AA 0E000003", log_wd[0][7:0], log_addr[0]);
      end
      do_access(32'h0E00_0001, 1'b0, 2'd0, 32'd0, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 9 || nrd != 1 || bus.rdata !== 32'h0101_0101) begin
         tests_failed++;
         $display("FAIL sram_read: tmo=%b cycles=%0d rd=%0d rdata=%h want 9 1 01010101",
                  tmo, cyc, nrd, bus.rdata);
      end
   endtask

   task automatic test_abort();
      int cyc, nrd, nwr; bit tmo;
      int late_rd;
      // WS2 N = 8 waits, S = 1 wait.
      waitcnt = 16'h0700; beef_mode = 1'b0;
      do_access(32'h0C00_0000, 1'b0, 2'd1, 32'd0, 1'b1, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 9 || bus.rdata !== 32'h1000_1000) begin
         tests_failed++;
         $display("FAIL ws2_N_read: tmo=%b cycles=%0d rdata=%h want 9 10001000", tmo, cyc, bus.rdata);
      end
      do_access(32'h0C00_0002, 1'b0, 2'd1, 32'd0, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 2 || bus.rdata !== 32'h1002_1002) begin
         tests_failed++;
         $display("FAIL ws2_S_read: tmo=%b cycles=%0d rdata=%h want 2 10021002", tmo, cyc, bus.rdata);
      end
      // Non-sequential 8-wait read, dropped in its third cycle.
      bus.addr = 32'h0C00_0010; bus.write = 1'b0; bus.size = 2'd1; bus.req = 1'b1;
      @(negedge clk);
      #1;
      tests_run++;
      if (cart_rd !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_first_strobe: cart_rd=%b want 1", cart_rd);
      end
      @(negedge clk);
      bus.req = 1'b0;
      late_rd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (cart_rd === 1'b1 || cart_wr === 1'b1) late_rd++;
      end
      tests_run++;
      if (late_rd != 0 || bus.rdata !== 32'h1002_1002) begin
         tests_failed++;
         $display("FAIL abort_no_strobe_capture: strobes=%0d rdata=%h want 0 10021002", late_rd, bus.rdata);
      end
      // Sequential to the last completed access, but the abort cleared eligibility.
      do_access(32'h0C00_0004, 1'b0, 2'd1, 32'd0, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 9) begin
         tests_failed++;
         $display("FAIL abort_then_N: tmo=%b cycles=%0d want 9", tmo, cyc);
      end
   endtask

   task automatic test_reset_mid_access();
      int cyc, nrd, nwr; bit tmo;
      waitcnt = 16'h0018; beef_mode = 1'b0;
      do_access(32'h0800_0010, 1'b0, 2'd2, 32'd0, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 5 || bus.rdata !== 32'h1012_1010) begin
         tests_failed++;
         $display("FAIL pre_reset_word: tmo=%b cycles=%0d rdata=%h want 5 10121010", tmo, cyc, bus.rdata);
      end
      // Sequential word: IDLE, one ACC_LO cycle, then ACC_HI.
      bus.addr = 32'h0800_0014; bus.write = 1'b0; bus.size = 2'd2; bus.req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      tests_run++;
      if (cart_rd !== 1'b1 || cart_addr !== 32'h0800_0016) begin
         tests_failed++;
         $display("FAIL hi_strobe_before_reset: rd=%b addr=%h want 1 08000016", cart_rd, cart_addr);
      end
      #1 rst_b = 1'b0;
      #1;
      tests_run++;
      if (cart_rd !== 1'b0 || cart_wr !== 1'b0 || cart_addr !== 32'd0 || bus.rdata !== 32'd0 ||
          cart_wdata !== 16'd0 || bus.pause !== 1'b1) begin
         tests_failed++;
         $display("FAIL async_reset: rd=%b wr=%b addr=%h rdata=%h wd=%h pause=%b want 0 0 0 0 0 1",
                  cart_rd, cart_wr, cart_addr, bus.rdata, cart_wdata, bus.pause);
      end
      bus.req = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      do_access(32'h0800_0014, 1'b0, 2'd2, 32'd0, 1'b0, cyc, nrd, nwr, tmo);
      tests_run++;
      if (tmo || cyc != 5) begin
         tests_failed++;
         $display("FAIL post_reset_N: tmo=%b cycles=%0d want 5", tmo, cyc);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      n_log        = 0;
      beef_mode    = 1'b0;
      waitcnt      = 16'h0000;
      rst_b        = 1'b0;
      bus.req      = 1'b0;
      bus.addr     = 32'd0;
      bus.write    = 1'b0;
      bus.size     = 2'd0;
      bus.wdata    = 32'd0;
      @(negedge clk);
      test_reset();
      test_half_read();
      test_back_to_back();
      test_seq_boundary();
      test_sram();
      test_abort();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
